// File: rtl/integer_unit.sv
// Execute-stage RV32 integer ALU: bitwise, add/sub and compare on one shared
// 33-bit adder, with a combinational result/flag and an enabled registered copy.
module integer_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Enable,
  input  logic [31:0] Rs1,
  input  logic [31:0] Rs2,
  input  logic [3:0]  CtrlALUOp,
  input  logic        CtrlFlagInv,
  output logic [31:0] Rd,
  output logic        Flag,
  output logic [31:0] RdQ,
  output logic        FlagQ
);

  localparam logic [1:0] CAT_BIT   = 2'b00;
  localparam logic [1:0] CAT_ADD   = 2'b01;
  localparam logic [1:0] CAT_SHIFT = 2'b10;
  localparam logic [1:0] CAT_FLAG  = 2'b11;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SLTU = 2'b10;
  localparam logic [1:0] OP_EQ   = 2'b11;

  // Signed less-than from the subtractor output: sign(diff) corrected by overflow.
  function automatic logic signed_lt(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input logic signed [31:0] diff);
    logic ovf;
    ovf = (a[31] != b[31]) && (diff[31] != a[31]);
    return diff[31] ^ ovf;
  endfunction

  logic [1:0]         cat;
  logic [1:0]         op;
  logic               sub_op;
  logic [31:0]        opb;
  logic [32:0]        addsum;
  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;
  logic signed [31:0] res_s;
  logic               raw_flag;

  logic [31:0]        rd_d;
  logic [31:0]        rd_q;
  logic               flag_d;
  logic               flag_q;

  assign cat   = CtrlALUOp[3:2];
  assign op    = CtrlALUOp[1:0];
  assign rs1_s = Rs1;
  assign rs2_s = Rs2;

  // The adder adds only for op 01 (ADD result and carry flag); every other
  // operation code wants the difference, so one adder serves all categories.
  assign sub_op = (op != OP_ADD);
  assign opb    = sub_op ? ~Rs2 : Rs2;
  assign addsum = {1'b0, Rs1} + {1'b0, opb} + {32'b0, sub_op};
  assign res_s  = addsum[31:0];

  always_comb begin
    raw_flag = 1'b0;
    case (op)
      OP_SLT:  raw_flag = signed_lt(rs1_s, rs2_s, res_s);
      OP_ADD:  raw_flag = addsum[32];
      OP_SLTU: raw_flag = ~addsum[32];
      OP_EQ:   raw_flag = (addsum[31:0] == 32'h0);
      default: raw_flag = 1'b0;
    endcase
  end

  assign Flag = raw_flag ^ CtrlFlagInv;

  always_comb begin
    Rd = 32'h0;
    case (cat)
      CAT_BIT: begin
        case (op)
          2'b00:   Rd = Rs2;
          2'b01:   Rd = Rs1 ^ Rs2;
          2'b10:   Rd = Rs1 | Rs2;
          default: Rd = Rs1 & Rs2;
        endcase
      end
      CAT_ADD:   Rd = addsum[31:0];
      CAT_SHIFT: Rd = 32'h0;
      CAT_FLAG:  Rd = {31'b0, Flag};
      default:   Rd = 32'h0;
    endcase
  end

  assign rd_d   = Enable ? Rd   : rd_q;
  assign flag_d = Enable ? Flag : flag_q;

  // Output register stage: one-cycle copy of Rd/Flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q   <= 32'h0;
      flag_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      flag_q <= flag_d;
    end
  end

  assign RdQ   = rd_q;
  assign FlagQ = flag_q;

endmodule

// File: tb/tb_integer_unit.sv
// Directed bench for integer_unit: combinational result/flag and registered copies.
module tb_integer_unit;

  logic        clk;
  logic        rst;
  logic        Enable;
  logic [31:0] Rs1;
  logic [31:0] Rs2;
  logic [3:0]  CtrlALUOp;
  logic        CtrlFlagInv;
  logic [31:0] Rd;
  logic        Flag;
  logic [31:0] RdQ;
  logic        FlagQ;

  int checks;
  int errors;

  integer_unit dut (
    .clk         (clk),
    .rst         (rst),
    .Enable      (Enable),
    .Rs1         (Rs1),
    .Rs2         (Rs2),
    .CtrlALUOp   (CtrlALUOp),
    .CtrlFlagInv (CtrlFlagInv),
    .Rd          (Rd),
    .Flag        (Flag),
    .RdQ         (RdQ),
    .FlagQ       (FlagQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [3:0] op, input logic inv,
                       input logic [31:0] a, input logic [31:0] b);
    CtrlALUOp   = op;
    CtrlFlagInv = inv;
    Rs1         = a;
    Rs2         = b;
    #1;
  endtask

  task automatic test_reset;
    rst    = 1'b0;
    Enable = 1'b1;
    apply(4'b0000, 1'b0, 32'h0, 32'h0000_00A5);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'h0) begin
      errors++; $display("FAIL reset_rdq actual=%h required=%h", RdQ, 32'h0);
    end
    checks++;
    if (FlagQ !== 1'b0) begin
      errors++; $display("FAIL reset_flagq actual=%b required=%b", FlagQ, 1'b0);
    end
    checks++;
    if (Rd !== 32'h0000_00A5) begin
      errors++; $display("FAIL reset_comb_rd actual=%h required=%h", Rd, 32'h0000_00A5);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'h0000_00A5) begin
      errors++; $display("FAIL reset_first_capture actual=%h required=%h", RdQ, 32'h0000_00A5);
    end
  endtask

  task automatic test_addsub;
    @(negedge clk);
    apply(4'b0101, 1'b0, 32'hFFFF_FFFF, 32'h1);
    checks++;
    if (Rd !== 32'h0) begin
      errors++; $display("FAIL add_wrap_rd actual=%h required=%h", Rd, 32'h0);
    end
    checks++;
    if (Flag !== 1'b1) begin
      errors++; $display("FAIL add_carry_flag actual=%b required=%b", Flag, 1'b1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'h0 || FlagQ !== 1'b1) begin
      errors++; $display("FAIL add_registered actual=%h/%b required=%h/%b", RdQ, FlagQ, 32'h0, 1'b1);
    end
    @(negedge clk);
    apply(4'b0100, 1'b0, 32'd5, 32'd7);
    checks++;
    if (Rd !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sub_rd actual=%h required=%h", Rd, 32'hFFFF_FFFE);
    end
    checks++;
    if (Flag !== 1'b1) begin
      errors++; $display("FAIL sub_slt_flag actual=%b required=%b", Flag, 1'b1);
    end
    apply(4'b0111, 1'b0, 32'd10, 32'd3);
    checks++;
    if (Rd !== 32'd7) begin
      errors++; $display("FAIL sub_op11_rd actual=%h required=%h", Rd, 32'd7);
    end
  endtask

  task automatic test_bitwise;
    @(negedge clk);
    apply(4'b0001, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checks++;
    if (Rd !== 32'hFF00_FF00) begin
      errors++; $display("FAIL xor_rd actual=%h required=%h", Rd, 32'hFF00_FF00);
    end
    apply(4'b0010, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checks++;
    if (Rd !== 32'hFFF0_FFF0) begin
      errors++; $display("FAIL or_rd actual=%h required=%h", Rd, 32'hFFF0_FFF0);
    end
    apply(4'b0011, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checks++;
    if (Rd !== 32'h00F0_00F0) begin
      errors++; $display("FAIL and_rd actual=%h required=%h", Rd, 32'h00F0_00F0);
    end
    apply(4'b0000, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checks++;
    if (Rd !== 32'h0FF0_0FF0) begin
      errors++; $display("FAIL nop_rd actual=%h required=%h", Rd, 32'h0FF0_0FF0);
    end
  endtask

  task automatic test_compare;
    @(negedge clk);
    apply(4'b1100, 1'b0, 32'h8000_0000, 32'h1);
    checks++;
    if (Rd !== 32'h1) begin
      errors++; $display("FAIL slt_rd actual=%h required=%h", Rd, 32'h1);
    end
    apply(4'b1110, 1'b0, 32'h8000_0000, 32'h1);
    checks++;
    if (Rd !== 32'h0) begin
      errors++; $display("FAIL sltu_rd actual=%h required=%h", Rd, 32'h0);
    end
    apply(4'b1110, 1'b1, 32'h8000_0000, 32'h1);
    checks++;
    if (Rd !== 32'h1) begin
      errors++; $display("FAIL sltu_inv_rd actual=%h required=%h", Rd, 32'h1);
    end
    apply(4'b1100, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (Rd !== 32'h0) begin
      errors++; $display("FAIL slt_overflow_rd actual=%h required=%h", Rd, 32'h0);
    end
    apply(4'b1100, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
    checks++;
    if (Rd !== 32'h1) begin
      errors++; $display("FAIL slt_overflow_neg_rd actual=%h required=%h", Rd, 32'h1);
    end
  endtask

  task automatic test_branch;
    @(negedge clk);
    apply(4'b1111, 1'b0, 32'h1234_5678, 32'h1234_5678);
    checks++;
    if (Flag !== 1'b1 || Rd !== 32'h1) begin
      errors++; $display("FAIL beq_flag actual=%b/%h required=%b/%h", Flag, Rd, 1'b1, 32'h1);
    end
    apply(4'b1111, 1'b1, 32'h1234_5678, 32'h1234_5678);
    checks++;
    if (Flag !== 1'b0) begin
      errors++; $display("FAIL bne_flag actual=%b required=%b", Flag, 1'b0);
    end
    apply(4'b1100, 1'b1, 32'h1234_5678, 32'h1234_5678);
    checks++;
    if (Flag !== 1'b1) begin
      errors++; $display("FAIL bge_flag actual=%b required=%b", Flag, 1'b1);
    end
    apply(4'b1111, 1'b0, 32'h1234_5678, 32'h1234_5679);
    checks++;
    if (Flag !== 1'b0) begin
      errors++; $display("FAIL beq_ne_flag actual=%b required=%b", Flag, 1'b0);
    end
  endtask

  task automatic test_enable_hold;
    @(negedge clk);
    Enable = 1'b1;
    apply(4'b0101, 1'b0, 32'd4, 32'd5);
    @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'd9 || FlagQ !== 1'b0) begin
      errors++; $display("FAIL en_capture actual=%h/%b required=%h/%b", RdQ, FlagQ, 32'd9, 1'b0);
    end
    @(negedge clk);
    Enable = 1'b0;
    apply(4'b1000, 1'b0, 32'd1, 32'd2);
    checks++;
    if (Rd !== 32'h0) begin
      errors++; $display("FAIL shift_rd actual=%h required=%h", Rd, 32'h0);
    end
    checks++;
    if (Flag !== 1'b1) begin
      errors++; $display("FAIL shift_cat_flag actual=%b required=%b", Flag, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'd9 || FlagQ !== 1'b0) begin
      errors++; $display("FAIL en_hold actual=%h/%b required=%h/%b", RdQ, FlagQ, 32'd9, 1'b0);
    end
    @(negedge clk);
    Enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'h0 || FlagQ !== 1'b1) begin
      errors++; $display("FAIL en_resume actual=%h/%b required=%h/%b", RdQ, FlagQ, 32'h0, 1'b1);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    apply(4'b1111, 1'b0, 32'h55, 32'h55);
    @(posedge clk);
    #1;
    checks++;
    if (RdQ !== 32'h1 || FlagQ !== 1'b1) begin
      errors++; $display("FAIL pre_async_capture actual=%h/%b required=%h/%b", RdQ, FlagQ, 32'h1, 1'b1);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (RdQ !== 32'h0 || FlagQ !== 1'b0) begin
      errors++; $display("FAIL async_reset actual=%h/%b required=%h/%b", RdQ, FlagQ, 32'h0, 1'b0);
    end
    checks++;
    if (Rd !== 32'h1 || Flag !== 1'b1) begin
      errors++; $display("FAIL async_reset_comb actual=%h/%b required=%h/%b", Rd, Flag, 32'h1, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    Enable      = 1'b0;
    Rs1         = 32'h0;
    Rs2         = 32'h0;
    CtrlALUOp   = 4'b0000;
    CtrlFlagInv = 1'b0;
    test_reset;
    test_addsub;
    test_bitwise;
    test_compare;
    test_branch;
    test_enable_hold;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
